label_stat: RTL and testbench

LABEL_STAT -- requirements
Module: label_stat

---
 rtl/label_stat_pkg.sv | 13 +
 rtl/label_stat_entry.sv | 38 +++
 rtl/label_stat.sv | 115 +++++++++++
 tb/tb_label_stat.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/label_stat_pkg.sv
// label_stat_pkg: shared image geometry, label limits and controller state encoding.
package label_stat_pkg;

    localparam int MAX_LBL = 16;
    localparam int IMG_W   = 32;
    localparam int NPIX    = 1024;
    localparam int AREA_W  = 11;
    localparam int COORD_W = 5;
    localparam int ADDR_W  = 10;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

endpackage

// File: rtl/label_stat_entry.sv
// label_stat_entry: area counter and bounding box for a single label.
module label_stat_entry
    import label_stat_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               upd,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [AREA_W-1:0]  area,
    output logic [COORD_W-1:0] xmin,
    output logic [COORD_W-1:0] xmax,
    output logic [COORD_W-1:0] ymin,
    output logic [COORD_W-1:0] ymax
);

    logic first;

    assign first = area == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            area <= '0;
            xmin <= '0;
            xmax <= '0;
            ymin <= '0;
            ymax <= '0;
        end else if (upd) begin
            area <= area + 1'b1;
            xmin <= (first || x < xmin) ? x : xmin;
            xmax <= (first || x > xmax) ? x : xmax;
            ymin <= (first || y < ymin) ? y : ymin;
            ymax <= (first || y > ymax) ? y : ymax;
        end
    end

endmodule

// File: rtl/label_stat.sv
// label_stat: scans the label SRAM once per start, then emits area/bbox records
// for every non-empty label in ascending order over a valid/ready handshake.
module label_stat
    import label_stat_pkg::*;
#(
    parameter int MAX_LBL = label_stat_pkg::MAX_LBL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         sram_q,
    output logic [ADDR_W-1:0]  sram_a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_label,
    output logic [AREA_W-1:0]  out_area,
    output logic [COORD_W-1:0] out_xmin,
    output logic [COORD_W-1:0] out_xmax,
    output logic [COORD_W-1:0] out_ymin,
    output logic [COORD_W-1:0] out_ymax,
    output logic               overflow,
    output logic               done
);

    localparam int LW = $clog2(MAX_LBL + 2);

    state_t             state, next_state;
    logic [AREA_W-1:0]  cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [LW-1:0]      idx, cur, nxt, sel;
    logic [MAX_LBL:1]   mask;
    logic [AREA_W-1:0]  area_a [1:MAX_LBL];
    logic [COORD_W-1:0] xmin_a [1:MAX_LBL];
    logic [COORD_W-1:0] xmax_a [1:MAX_LBL];
    logic [COORD_W-1:0] ymin_a [1:MAX_LBL];
    logic [COORD_W-1:0] ymax_a [1:MAX_LBL];
    logic               start_ok, proc;

    // Lowest non-empty label at or above 'from'; 0 when none remain.
    function automatic logic [LW-1:0] next_lbl(input logic [MAX_LBL:1] m, input logic [LW-1:0] from);
        next_lbl = '0;
        for (int i = MAX_LBL; i >= 1; i--)
            if (m[i] && LW'(i) >= from) next_lbl = LW'(i);
    endfunction

    assign start_ok = start && (state == IDLE || state == DONE);
    assign proc     = state == SCAN && cnt != '0;
    assign sram_a   = cnt[ADDR_W] ? ADDR_W'(NPIX - 1) : cnt[ADDR_W-1:0];
    assign cur      = next_lbl(mask, idx);
    assign nxt      = next_lbl(mask, cur + 1'b1);

    for (genvar g = 1; g <= MAX_LBL; g++) begin : g_ent
        label_stat_entry u_ent (
            .clk  (clk),
            .reset(reset),
            .clr  (start_ok),
            .upd  (proc && sram_q == 8'(g)),
            .x    (addr_q[COORD_W-1:0]),
            .y    (addr_q[ADDR_W-1:COORD_W]),
            .area (area_a[g]),
            .xmin (xmin_a[g]),
            .xmax (xmax_a[g]),
            .ymin (ymin_a[g]),
            .ymax (ymax_a[g])
        );
        assign mask[g] = area_a[g] != '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Leaving EMIT on the accepting edge of the last record avoids a dead cycle.
    always_comb begin
        next_state = start_ok ? SCAN
                   : (state == SCAN && cnt == AREA_W'(NPIX)) ? EMIT
                   : (state == EMIT && (cur == '0 || (out_ready && nxt == '0))) ? DONE
                   : state;
    end

    always_comb begin
        out_valid = state == EMIT && cur != '0;
        done      = state == DONE;
        sel       = out_valid ? cur : LW'(1);
        out_label = out_valid ? 8'(cur) : '0;
        out_area  = out_valid ? area_a[sel] : '0;
        out_xmin  = out_valid ? xmin_a[sel] : '0;
        out_xmax  = out_valid ? xmax_a[sel] : '0;
        out_ymin  = out_valid ? ymin_a[sel] : '0;
        out_ymax  = out_valid ? ymax_a[sel] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            idx      <= LW'(1);
            overflow <= 1'b0;
        end else begin
            addr_q <= sram_a;
            if (start_ok) begin
                cnt      <= '0;
                idx      <= LW'(1);
                overflow <= 1'b0;
            end else if (state == SCAN) begin
                cnt      <= cnt + 1'b1;
                overflow <= overflow | (proc && sram_q > 8'(MAX_LBL));
            end else if (out_valid && out_ready) begin
                idx <= cur + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_label_stat.sv
// tb_label_stat: randomized scoreboard bench; records expected from a per-label image model.
module tb_label_stat;

    typedef struct {
        int label;
        int area;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  sram_q;
    logic [9:0]  sram_a;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_label;
    logic [10:0] out_area;
    logic [4:0]  out_xmin, out_xmax, out_ymin, out_ymax;
    logic        overflow;
    logic        done;

    logic [7:0]  mem [1024];
    rec_t        exp_q [$];
    int          exp_ovf;
    int          passed = 0;
    int          total  = 0;

    label_stat dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sram_q   (sram_q),
        .sram_a   (sram_a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_label(out_label),
        .out_area (out_area),
        .out_xmin (out_xmin),
        .out_xmax (out_xmax),
        .out_ymin (out_ymin),
        .out_ymax (out_ymax),
        .overflow (overflow),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= mem[sram_a];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Reference: for each label, scan the whole image and gather its pixels.
    task automatic build_expected();
        rec_t r;
        exp_ovf = 0;
        for (int p = 0; p < 1024; p++) if (mem[p] > 16) exp_ovf = 1;
        for (int l = 1; l <= 16; l++) begin
            r = '{l, 0, 99, -1, 99, -1};
            for (int p = 0; p < 1024; p++) begin
                if (mem[p] == l) begin
                    r.area++;
                    if (p % 32 < r.xmin) r.xmin = p % 32;
                    if (p % 32 > r.xmax) r.xmax = p % 32;
                    if (p / 32 < r.ymin) r.ymin = p / 32;
                    if (p / 32 > r.ymax) r.ymax = p / 32;
                end
            end
            if (r.area > 0) exp_q.push_back(r);
        end
    endtask

    // Every cycle a record is presented it must equal the scoreboard head; pop on accept.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_record: got label %0d area %0d, none expected", out_label, out_area);
            end else begin
                if (out_label == exp_q[0].label && out_area == exp_q[0].area &&
                    out_xmin == exp_q[0].xmin && out_xmax == exp_q[0].xmax &&
                    out_ymin == exp_q[0].ymin && out_ymax == exp_q[0].ymax)
                    passed++;
                else
                    $display("FAIL record: got lbl=%0d area=%0d x=%0d..%0d y=%0d..%0d expected lbl=%0d area=%0d x=%0d..%0d y=%0d..%0d",
                             out_label, out_area, out_xmin, out_xmax, out_ymin, out_ymax,
                             exp_q[0].label, exp_q[0].area, exp_q[0].xmin, exp_q[0].xmax, exp_q[0].ymin, exp_q[0].ymax);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic fill_rand(input int maxl);
        for (int p = 0; p < 1024; p++)
            mem[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, maxl)) : 8'd0;
    endtask

    task automatic run_scan(input bit stall_test, input int exp_done);
        int n, stall_left;
        bit stall_started;
        build_expected();
        stall_left    = 0;
        stall_started = 0;
        out_ready     = !stall_test;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (n == 0) check("scan_addr_first", sram_a, 0);
            if (n == 1) check("scan_addr_second", sram_a, 1);
            if (n == 1024) check("scan_addr_hold", sram_a, 1023);
            if (stall_left == 3) begin
                check("emit_start_ignored_addr", sram_a, 1023);
                check("emit_start_ignored_valid", out_valid, 1);
            end
            if (done) break;
            if (stall_test && out_valid && !stall_started) begin
                stall_started = 1;
                stall_left    = 10;
            end
            @(posedge clk); #1;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                start     = stall_left == 5;
                stall_left--;
            end else begin
                start     = 1'b0;
                out_ready = (stall_test && !stall_started) ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
        end
        check("done_reached", done, 1);
        if (exp_done >= 0) check("done_cycle", n, exp_done);
        check("overflow", overflow, exp_ovf);
        check("all_records_emitted", exp_q.size(), 0);
        check("done_no_valid", out_valid, 0);
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sram_a", sram_a, 0);
        check("reset_valid", out_valid, 0);
        check("reset_label", out_label, 0);
        check("reset_area", out_area, 0);
        check("reset_overflow", overflow, 0);
        check("reset_done", done, 0);
        reset = 1'b0;

        run_scan(1'b0, 1026);

        for (int p = 0; p < 1024; p++) mem[p] = 8'd1;
        run_scan(1'b0, -1);

        for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
        mem[5 * 32 + 2] = 8'd3;
        mem[31]         = 8'd1;
        run_scan(1'b0, -1);

        for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
        mem[100] = 8'd17;
        for (int y = 10; y <= 14; y++)
            for (int x = 4; x <= 9; x++) mem[y * 32 + x] = 8'd2;
        run_scan(1'b1, -1);

        fill_rand(16);
        build_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (501) @(negedge clk);
        check("midscan_addr", sram_a, 500);
        #2 reset = 1'b1;
        #1;
        check("midscan_reset_addr", sram_a, 0);
        check("midscan_reset_valid", out_valid, 0);
        check("midscan_reset_done", done, 0);
        check("midscan_reset_overflow", overflow, 0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_reset_valid", out_valid, 0);
        check("idle_after_reset_done", done, 0);
        run_scan(1'b0, -1);

        for (int t = 0; t < 3; t++) begin
            fill_rand(20);
            run_scan(1'b0, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
